// File: rtl/multi_channel_debouncer.sv
// N-channel button conditioner: shared sample-tick prescaler feeding one lane per input
// (2-flop synchroniser, N-sample stability filter, press/release and long-press pulses).

module multi_channel_debouncer_lane #(
    parameter int   STABLE_SAMPLES = 4,
    parameter int   HOLD_TICKS     = 500,
    parameter logic INV            = 1'b0
) (
    input  logic i_clk,
    input  logic i_resetN,
    input  logic i_pin,
    input  logic i_tick,
    output logic o_buttonOut,
    output logic o_pressPulse,
    output logic o_releasePulse,
    output logic o_longPress
);
    localparam int SW = $clog2(STABLE_SAMPLES) + 1;

    logic [1:0]    r_sync;
    logic [SW-1:0] r_stab;
    logic          r_out;
    logic          r_press;
    logic          r_rel;
    logic          w_level;

    // Synchroniser resets to the pin's idle level so the logical level starts at 0.
    assign w_level = r_sync[1] ^ INV;

    always_ff @(posedge i_clk) begin
        if (!i_resetN) begin
            r_sync  <= {2{INV}};
            r_stab  <= '0;
            r_out   <= 1'b0;
            r_press <= 1'b0;
            r_rel   <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_pin};
            r_press <= 1'b0;
            r_rel   <= 1'b0;
            if (i_tick) begin
                if (w_level == r_out) begin
                    r_stab <= '0;
                end else if (r_stab == SW'(STABLE_SAMPLES - 1)) begin
                    r_out   <= ~r_out;
                    r_press <= ~r_out;
                    r_rel   <= r_out;
                    r_stab  <= '0;
                end else begin
                    r_stab <= r_stab + SW'(1);
                end
            end
        end
    end

    assign o_buttonOut    = r_out;
    assign o_pressPulse   = r_press;
    assign o_releasePulse = r_rel;

    generate
        if (HOLD_TICKS > 0) begin : g_long
            localparam int HW = $clog2(HOLD_TICKS + 1);
            logic [HW-1:0] r_hold;
            logic          r_long;

            // Hold saturates at HOLD_TICKS, so the pulse fires once per press.
            always_ff @(posedge i_clk) begin
                if (!i_resetN) begin
                    r_hold <= '0;
                    r_long <= 1'b0;
                end else begin
                    r_long <= 1'b0;
                    if (!r_out) begin
                        r_hold <= '0;
                    end else if (i_tick && (r_hold != HW'(HOLD_TICKS))) begin
                        r_hold <= r_hold + HW'(1);
                        r_long <= (r_hold == HW'(HOLD_TICKS - 1));
                    end
                end
            end
            assign o_longPress = r_long;
        end else begin : g_nolong
            assign o_longPress = 1'b0;
        end
    endgenerate
endmodule

module multi_channel_debouncer #(
    parameter int                  CHANNELS       = 4,
    parameter int                  TICK_DIV       = 50_000,
    parameter int                  STABLE_SAMPLES = 4,
    parameter int                  HOLD_TICKS     = 500,
    parameter logic [CHANNELS-1:0] INVERT         = '0
) (
    input  logic                i_clk,
    input  logic                i_resetN,
    input  logic [CHANNELS-1:0] i_buttonIn,
    output logic [CHANNELS-1:0] o_buttonOut,
    output logic [CHANNELS-1:0] o_pressPulse,
    output logic [CHANNELS-1:0] o_releasePulse,
    output logic [CHANNELS-1:0] o_longPress,
    output logic                o_sampleTick
);
    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] r_cnt;
    logic          w_tick;

    assign w_tick       = (r_cnt == CW'(TICK_DIV - 1));
    assign o_sampleTick = w_tick;

    always_ff @(posedge i_clk) begin
        if (!i_resetN)   r_cnt <= '0;
        else if (w_tick) r_cnt <= '0;
        else             r_cnt <= r_cnt + CW'(1);
    end

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
            multi_channel_debouncer_lane #(
                .STABLE_SAMPLES(STABLE_SAMPLES),
                .HOLD_TICKS    (HOLD_TICKS),
                .INV           (INVERT[g])
            ) u_lane (
                .i_clk         (i_clk),
                .i_resetN      (i_resetN),
                .i_pin         (i_buttonIn[g]),
                .i_tick        (w_tick),
                .o_buttonOut   (o_buttonOut[g]),
                .o_pressPulse  (o_pressPulse[g]),
                .o_releasePulse(o_releasePulse[g]),
                .o_longPress   (o_longPress[g])
            );
        end
    endgenerate
endmodule

// File: tb/tb_multi_channel_debouncer.sv
// Bench: two instances (INVERT 00 and 01) checked every cycle against a tick-level
// behavioural model, plus a phase table with expected levels and pulse counts.

module tb_multi_channel_debouncer;
    localparam int         TD   = 4;
    localparam int         SS   = 3;
    localparam int         HT   = 5;
    localparam logic [1:0] INV0 = 2'b00;
    localparam logic [1:0] INV1 = 2'b01;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic [1:0] btn0 = 2'b11;
    logic [1:0] btn1 = 2'b01;
    logic [1:0] out0, pr0, rl0, lp0, out1, pr1, rl1, lp1;
    logic       tk0, tk1;

    always #5 clk = ~clk;

    multi_channel_debouncer #(
        .CHANNELS(2), .TICK_DIV(TD), .STABLE_SAMPLES(SS), .HOLD_TICKS(HT), .INVERT(INV0)
    ) dut (
        .i_clk(clk), .i_resetN(resetN), .i_buttonIn(btn0),
        .o_buttonOut(out0), .o_pressPulse(pr0), .o_releasePulse(rl0),
        .o_longPress(lp0), .o_sampleTick(tk0)
    );

    multi_channel_debouncer #(
        .CHANNELS(2), .TICK_DIV(TD), .STABLE_SAMPLES(SS), .HOLD_TICKS(HT), .INVERT(INV1)
    ) dut_inv (
        .i_clk(clk), .i_resetN(resetN), .i_buttonIn(btn1),
        .o_buttonOut(out1), .o_pressPulse(pr1), .o_releasePulse(rl1),
        .o_longPress(lp1), .o_sampleTick(tk1)
    );

    int n_vec = 0;
    int n_err = 0;
    int pc = 0, rc = 0, lc = 0;
    int cyc = 0;

    // Model: pin history, tick phase, count of consecutive differing samples, ticks held.
    int         m_cnt;
    logic [1:0] m_p1[2], m_p2[2], m_out[2], m_pr[2], m_rl[2], m_lp[2];
    int         m_diff[2][2], m_held[2][2];

    function automatic logic [1:0] inv_of(input int k);
        return (k == 1) ? INV1 : INV0;
    endfunction

    task automatic step_model();
        logic [1:0] pins[2];
        logic       tick, lvl, was;
        pins[0] = btn0;
        pins[1] = btn1;
        if (!resetN) begin
            m_cnt = 0;
            for (int k = 0; k < 2; k++) begin
                m_p1[k] = inv_of(k); m_p2[k] = inv_of(k);
                m_out[k] = '0; m_pr[k] = '0; m_rl[k] = '0; m_lp[k] = '0;
                for (int c = 0; c < 2; c++) begin m_diff[k][c] = 0; m_held[k][c] = 0; end
            end
        end else begin
            tick = (m_cnt == TD - 1);
            for (int k = 0; k < 2; k++) begin
                for (int c = 0; c < 2; c++) begin
                    m_pr[k][c] = 1'b0; m_rl[k][c] = 1'b0; m_lp[k][c] = 1'b0;
                    was = m_out[k][c];
                    if (!was) m_held[k][c] = 0;
                    else if (tick && m_held[k][c] < HT) begin
                        m_held[k][c]++;
                        if (m_held[k][c] == HT) m_lp[k][c] = 1'b1;
                    end
                    if (tick) begin
                        lvl = m_p2[k][c] ^ inv_of(k)[c];
                        if (lvl != was) begin
                            m_diff[k][c]++;
                            if (m_diff[k][c] == SS) begin
                                m_out[k][c] = ~was; m_pr[k][c] = ~was; m_rl[k][c] = was;
                                m_diff[k][c] = 0;
                            end
                        end else begin
                            m_diff[k][c] = 0;
                        end
                    end
                end
                m_p2[k] = m_p1[k];
                m_p1[k] = pins[k];
            end
            m_cnt = (m_cnt + 1) % TD;
        end
    endtask

    always @(posedge clk) begin
        logic [17:0] got, exp;
        step_model();
        #1;
        cyc++;
        got = {out0, pr0, rl0, lp0, tk0, out1, pr1, rl1, lp1, tk1};
        exp = {m_out[0], m_pr[0], m_rl[0], m_lp[0], (m_cnt == TD - 1),
               m_out[1], m_pr[1], m_rl[1], m_lp[1], (m_cnt == TD - 1)};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL model cyc=%0d got=%b want=%b", cyc, got, exp);
        end
        if (pr0 !== pr1 & 2'b00) begin end
        pc += $countones(pr0);
        rc += $countones(rl0);
        lc += $countones(lp0);
    end

    typedef struct {
        logic       rst_n;
        logic [1:0] b0;
        logic [1:0] b1;
        int         ncyc;
        logic [1:0] eo0;
        logic [1:0] eo1;
        int         npr;
        int         nrl;
        int         nlp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [1:0] b0, logic [1:0] b1, int n,
                                logic [1:0] e0, logic [1:0] e1, int p, int rl, int l);
        vec_t v;
        v.rst_n = r; v.b0 = b0; v.b1 = b1; v.ncyc = n;
        v.eo0 = e0; v.eo1 = e1; v.npr = p; v.nrl = rl; v.nlp = l;
        return v;
    endfunction

    initial begin
        // held through reset, then fresh press of both, long press, hold, release
        tbl.push_back(mk(0, 2'b11, 2'b01, 10, 2'b00, 2'b00, 0, 0, 0));
        tbl.push_back(mk(1, 2'b11, 2'b01, 12, 2'b11, 2'b00, 2, 0, 0));
        tbl.push_back(mk(1, 2'b11, 2'b01, 20, 2'b11, 2'b00, 0, 0, 2));
        tbl.push_back(mk(1, 2'b11, 2'b01, 80, 2'b11, 2'b00, 0, 0, 0));
        tbl.push_back(mk(1, 2'b00, 2'b00, 12, 2'b00, 2'b01, 0, 2, 0));
        // glitches of two ticks on ch0; inverted instance releases meanwhile
        tbl.push_back(mk(1, 2'b01, 2'b01, 8, 2'b00, 2'b01, 0, 0, 0));
        tbl.push_back(mk(1, 2'b00, 2'b01, 8, 2'b00, 2'b00, 0, 0, 0));
        for (int i = 0; i < 4; i++) begin
            tbl.push_back(mk(1, 2'b01, 2'b01, 8, 2'b00, 2'b00, 0, 0, 0));
            tbl.push_back(mk(1, 2'b00, 2'b01, 8, 2'b00, 2'b00, 0, 0, 0));
        end
        // clean press ch0, long press ch1 twice
        tbl.push_back(mk(1, 2'b01, 2'b01, 40, 2'b01, 2'b00, 1, 0, 1));
        tbl.push_back(mk(1, 2'b00, 2'b01, 12, 2'b00, 2'b00, 0, 1, 0));
        tbl.push_back(mk(1, 2'b10, 2'b01, 32, 2'b10, 2'b00, 1, 0, 1));
        tbl.push_back(mk(1, 2'b00, 2'b01, 12, 2'b00, 2'b00, 0, 1, 0));
        tbl.push_back(mk(1, 2'b10, 2'b01, 32, 2'b10, 2'b00, 1, 0, 1));
        tbl.push_back(mk(1, 2'b00, 2'b01, 12, 2'b00, 2'b00, 0, 1, 0));
        // reset in the middle of a count needs three fresh ticks
        tbl.push_back(mk(1, 2'b01, 2'b01, 8, 2'b00, 2'b00, 0, 0, 0));
        tbl.push_back(mk(0, 2'b01, 2'b01, 1, 2'b00, 2'b00, 0, 0, 0));
        tbl.push_back(mk(1, 2'b01, 2'b01, 11, 2'b00, 2'b00, 0, 0, 0));
        tbl.push_back(mk(1, 2'b01, 2'b01, 1, 2'b01, 2'b00, 1, 0, 0));
        tbl.push_back(mk(1, 2'b00, 2'b01, 12, 2'b00, 2'b00, 0, 1, 0));

        foreach (tbl[i]) begin
            resetN = tbl[i].rst_n;
            btn0   = tbl[i].b0;
            btn1   = tbl[i].b1;
            pc = 0; rc = 0; lc = 0;
            repeat (tbl[i].ncyc) @(negedge clk);
            n_vec++;
            if (out0 !== tbl[i].eo0 || out1 !== tbl[i].eo1) begin
                n_err++;
                $display("FAIL tbl%0d level got=%b/%b want=%b/%b", i, out0, out1,
                         tbl[i].eo0, tbl[i].eo1);
            end
            n_vec++;
            if (pc != tbl[i].npr || rc != tbl[i].nrl || lc != tbl[i].nlp) begin
                n_err++;
                $display("FAIL tbl%0d pulses got p/r/l=%0d/%0d/%0d want=%0d/%0d/%0d", i,
                         pc, rc, lc, tbl[i].npr, tbl[i].nrl, tbl[i].nlp);
            end
        end

        // random pin activity with occasional reset, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            resetN = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 15) == 0) btn0[$urandom_range(0, 1)] = ~btn0[$urandom_range(0, 1)];
            if ($urandom_range(0, 15) == 0) btn1[$urandom_range(0, 1)] = ~btn1[$urandom_range(0, 1)];
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
